// File: rtl/musa_pkg.sv
// musa_pkg: shared MUSA core constants and the return-stack operation decode
package musa_pkg;
    localparam int PC_W = 32;
    localparam int CALL_STACK_DEPTH = 8;
    typedef enum logic [1:0] {NONE, PUSH, POP, REPLACE} stack_op_t;
    // A push together with a pop on an empty stack is a plain push; a lone pop on empty does nothing
    function automatic stack_op_t decode_op(input logic p, input logic q, input logic e);
        return (p && q && !e) ? REPLACE : p ? PUSH : (q && !e) ? POP : NONE;
    endfunction
endpackage

// File: rtl/call_stack_mem.sv
// call_stack_mem: DEPTH x ADDR_W register array, one sync write port, one async read port
//   clk, we/waddr/wdata (write on rising edge), raddr -> rdata (combinational)
module call_stack_mem #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ADDR_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ADDR_W-1:0]        rdata
);
    logic [ADDR_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/call_stack.sv
// call_stack: hardware return-address stack for CALL/RET with fill level and sticky errors
//   clk, rst_n (sync, active-low); push/pop strobes, push_addr, clr_err
//   ret_addr (top entry, 0 when empty), empty, full, count, overflow, underflow
//   Define CALL_STACK_WRAP_EN for the circular build (push when full overwrites the oldest entry)
module call_stack
    import musa_pkg::*;
#(
    parameter int DEPTH  = CALL_STACK_DEPTH,
    parameter int ADDR_W = PC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic                       clr_err,
    output logic [ADDR_W-1:0]          ret_addr,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
`ifdef CALL_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    stack_op_t op;
    logic [PW-1:0] sp, top, waddr;
    logic [ADDR_W-1:0] rdata;
    logic we, grow, ovf_set, unf_set;
    always_comb begin
        op      = decode_op(push, pop, empty);
        top     = sp - PW'(1);
        waddr   = (op == REPLACE) ? top : sp;
        grow    = op == PUSH && !full;
        we      = rst_n && (op == REPLACE || (op == PUSH && (!full || WRAP)));
        ovf_set = op == PUSH && full && !WRAP;
        unf_set = pop && !push && empty;
    end
    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign ret_addr = empty ? '0 : rdata;
    call_stack_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk(clk), .we(we), .waddr(waddr), .wdata(push_addr), .raddr(top), .rdata(rdata)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // A replace writes the top in place; a wrapped push advances sp but keeps count at DEPTH
            if (we && op == PUSH) sp <= sp + PW'(1);
            if (op == POP) sp <= top;
            if (grow) count <= count + CW'(1);
            else if (op == POP) count <= count - CW'(1);
            overflow  <= ovf_set | (overflow & ~clr_err);
            underflow <= unf_set | (underflow & ~clr_err);
        end
    end
endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: directed + random self-checking bench for call_stack against a queue model
module tb_call_stack;
    localparam int DEPTH = 8;
`ifdef CALL_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    logic clk = 0, rst_n = 1, push = 0, pop = 0, clr_err = 0;
    logic [31:0] push_addr = 0, ret_addr;
    logic empty, full, overflow, underflow;
    logic [3:0] count;
    int n_chk = 0, n_fail = 0;

    call_stack #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_addr(push_addr),
        .clr_err(clr_err), .ret_addr(ret_addr), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue with the newest entry at the back
    logic [31:0] mq[$];
    bit m_ovf, m_unf, started, o, u;
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
            started = 1;
        end else begin
            o = 0;
            u = 0;
            if (push && pop && mq.size() > 0) mq[mq.size()-1] = push_addr;
            else if (push) begin
                if (mq.size() < DEPTH) mq.push_back(push_addr);
                else if (WRAP) begin
                    void'(mq.pop_front());
                    mq.push_back(push_addr);
                end else o = 1;
            end else if (pop) begin
                if (mq.size() > 0) void'(mq.pop_back());
                else u = 1;
            end
            m_ovf = o | (m_ovf & !clr_err);
            m_unf = u | (m_unf & !clr_err);
        end
        #1;
        if (started) begin
            chk("m_ret", ret_addr, mq.size() > 0 ? mq[mq.size()-1] : 32'h0);
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_empty", 32'(empty), 32'(mq.size() == 0));
            chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
            chk("m_ovf", 32'(overflow), 32'(m_ovf));
            chk("m_unf", 32'(underflow), 32'(m_unf));
        end
    end

    task automatic op(input logic p, input logic q, input logic [31:0] a, input logic c, input logic r);
        push = p; pop = q; push_addr = a; clr_err = c; rst_n = r;
        @(negedge clk);
        push = 0; pop = 0; clr_err = 0; rst_n = 1;
    endtask

    initial begin
        @(negedge clk);
        op(0, 0, 0, 0, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ret", ret_addr, 0);
        chk("rst_flags", {30'b0, overflow, underflow}, 0);
        op(1, 0, 32'h10, 0, 1);
        op(1, 0, 32'h20, 0, 1);
        op(1, 0, 32'h30, 0, 1);
        chk("lifo_count", 32'(count), 3);
        chk("lifo_top", ret_addr, 32'h30);
        op(0, 1, 0, 0, 1);
        chk("lifo_pop1", ret_addr, 32'h20);
        op(0, 1, 0, 0, 1);
        chk("lifo_pop2", ret_addr, 32'h10);
        op(0, 1, 0, 0, 1);
        chk("lifo_empty", 32'(empty), 1);
        chk("lifo_ret0", ret_addr, 0);
        op(0, 1, 0, 0, 1);
        chk("unf_set", 32'(underflow), 1);
        chk("unf_count", 32'(count), 0);
        op(0, 0, 0, 1, 1);
        chk("unf_clr", 32'(underflow), 0);
        for (int i = 1; i <= 9; i++) op(1, 0, 32'(i), 0, 1);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 8);
        chk("fill_ovf", 32'(overflow), WRAP ? 0 : 1);
        chk("fill_top", ret_addr, WRAP ? 32'h9 : 32'h8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_top", ret_addr, WRAP ? 32'(9 - i) : 32'(8 - i));
            op(0, 1, 0, 0, 1);
        end
        chk("drain_empty", 32'(empty), 1);
        op(0, 0, 0, 1, 1);
        op(1, 0, 32'hA0, 0, 1);
        op(1, 0, 32'hB0, 0, 1);
        op(1, 1, 32'hC0, 0, 1);
        chk("repl_count", 32'(count), 2);
        chk("repl_top", ret_addr, 32'hC0);
        op(0, 1, 0, 0, 1);
        chk("repl_pop", ret_addr, 32'hA0);
        op(0, 1, 0, 0, 1);
        op(1, 1, 32'h44, 0, 1);
        chk("pp_empty_count", 32'(count), 1);
        chk("pp_empty_top", ret_addr, 32'h44);
        chk("pp_empty_unf", 32'(underflow), 0);
        op(0, 1, 0, 0, 1);
        for (int i = 0; i < 8; i++) op(1, 0, 32'h100 + 32'(i), 0, 1);
        op(1, 1, 32'h1FF, 0, 1);
        chk("full_repl_ovf", 32'(overflow), 0);
        chk("full_repl_top", ret_addr, 32'h1FF);
        for (int i = 0; i < 8; i++) op(0, 1, 0, 0, 1);
        op(0, 1, 0, 1, 1);
        chk("clr_vs_set", 32'(underflow), 1);
        for (int i = 0; i < 5; i++) op(1, 0, 32'h200 + 32'(i), 0, 1);
        op(1, 0, 32'h2FF, 0, 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_flags", {30'b0, overflow, underflow}, 0);
        chk("midrst_ret", ret_addr, 0);
        for (int i = 0; i < 400; i++)
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom,
               $urandom_range(0, 15) == 0, $urandom_range(0, 60) != 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/call_stack.md
# call_stack

Hardware return-address stack for the MUSA core. It sits beside the ID-stage control unit and consumes that unit's `push` (CALL) and `pop` (RET) strobes. On CALL it stores the return PC. On RET it presents the saved PC to the PC-select mux. It reports fill level and sticky overflow/underflow errors so that HALT/debug logic can detect call-depth faults.

## Interface
Parameters:
- `DEPTH`, 8: number of return-address entries; power of two, 2..64.
- `ADDR_W`, 32: PC / return-address width.

Ports:
- `clk`, in, 1: core clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `push`, in, 1: CALL strobe from the control unit; one push per cycle high.
- `pop`, in, 1: RET strobe from the control unit; one pop per cycle high.
- `push_addr`, in, ADDR_W: return address (PC+1) written on push.
- `clr_err`, in, 1: clears the sticky error flags.
- `ret_addr`, out, ADDR_W: current top-of-stack entry; 0 when empty.
- `empty`, out, 1: count == 0.
- `full`, out, 1: count == DEPTH.
- `count`, out, $clog2(DEPTH+1): number of valid entries.
- `overflow`, out, 1: sticky; a push was attempted while full (non-wrap build only).
- `underflow`, out, 1: sticky; a pop was attempted while empty.

## Operation
- State:
  - entry array `mem[DEPTH]`;
  - write pointer `sp`, width $clog2(DEPTH), wraps modulo DEPTH;
  - `count`.
- Top of stack is `mem[sp-1]` (modulo DEPTH).
- `ret_addr` is the combinational read of the top entry, gated to 0 when empty. The control unit samples it in the same cycle it asserts `pop`.
- Push only: `mem[sp] <= push_addr`, `sp <= sp+1`, `count <= count+1`.
- Pop only, not empty: `sp <= sp-1`, `count <= count-1`. Entry contents are left untouched.
- Pop only, empty: no state change; `underflow <= 1`.
- Push and pop in the same cycle, not empty: replace the top entry (`mem[sp-1] <= push_addr`); `sp` and `count` unchanged.
- Push and pop in the same cycle, empty: behaves as a plain push; no underflow.
- Push when full: behaviour depends on the build (see Configuration).
- Error flags:
  - Once set, a flag holds until `clr_err` or reset.
  - A `clr_err` in the same cycle as a new error leaves the flag set (set wins).

## Timing
- Reset (`rst_n` low at a rising edge): `sp=0`, `count=0`, `empty=1`, `full=0`, `overflow=0`, `underflow=0`, `ret_addr=0`. Array contents are not reset.
- A reset asserted mid-sequence discards every entry in one cycle. Any push/pop in that cycle is ignored.
- Push-to-visible latency is 1 cycle: `ret_addr` shows the new value in the cycle after `push`.
- Pop-to-next-top latency is 1 cycle. `ret_addr` during the `pop` cycle is the entry being popped.
- `empty`, `full` and `count` are derived from registered state; no combinational path from `push`/`pop` to any output.
- Back-to-back pushes and pops every cycle are supported with no bubbles.

## Configuration
- `CALL_STACK_WRAP_EN` defined (circular):
  - Push when full overwrites the oldest entry: `mem[sp] <= push_addr`, `sp <= sp+1`.
  - `count` stays at DEPTH; `overflow` is never set.
  - Deep recursion keeps the most recent DEPTH return addresses.
- `CALL_STACK_WRAP_EN` undefined (default):
  - Push when full is dropped; `sp`, `count` and `mem` are unchanged.
  - `overflow <= 1`.
  - Push and pop together while full is still a legal replace and is not an overflow.

## Structure
- Shared package `musa_pkg`:
  - `PC_W` constant, used as the `ADDR_W` default;
  - `CALL_STACK_DEPTH` default;
  - `stack_op_t` enum {NONE, PUSH, POP, REPLACE}, decoded from {push, pop, empty}.
- Sub-module `call_stack_mem`: DEPTH×ADDR_W register array with one synchronous write port and one asynchronous read port.
- `call_stack` itself holds the pointer, count, flags and op decode.

## Test plan
- Reset, then push 0x10, 0x20, 0x30 on consecutive cycles -> `count=3`, `ret_addr=0x30`; pop ×3 -> `ret_addr` reads 0x30, 0x20, 0x10 in order, then `empty=1`, `ret_addr=0`.
- Pop on an empty stack -> `underflow=1`, `count=0`; `clr_err` pulse -> `underflow=0` next cycle.
- DEPTH=8, push 0x1..0x9:
  - non-wrap build -> `full=1`, `overflow=1`, `ret_addr=0x8`;
  - wrap build -> `ret_addr=0x9`, `count=8`; popping 8 times yields 0x9 down to 0x2.
- Stack holds 0xA0, 0xB0; push 0xC0 and pop in the same cycle -> `count=2`, `ret_addr=0xC0`; pop -> 0xA0.
- Push 0x44 and pop together on an empty stack -> `count=1`, `ret_addr=0x44`, `underflow=0`.
- Push 5 entries, assert `rst_n=0` for 1 cycle alongside a push -> `count=0`, `empty=1`, all flags 0.
